// File: rtl/rom_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// rom_arbiter_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the ROM arbiter:
//   - controller state encoding
//   - requester index constants
//   - address/data widths and the wait-state timeout
//   - round-robin selection helper for requesters 1..3
// Revision: 1.0 - initial release
// ============================================================================
package rom_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam int unsigned NUM_RQ = 4;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 16;

  localparam logic [1:0] RQ_PLANES  = 2'd0;
  localparam logic [1:0] RQ_SPRITES = 2'd1;
  localparam logic [1:0] RQ_68K     = 2'd2;
  localparam logic [1:0] RQ_Z80     = 2'd3;

  localparam logic [7:0]        TIMEOUT      = 8'd255;
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 16'hFFFF;

  // Round-robin pick among requesters 1..3, starting the search at ptr.
  // Returns {found, index}. Bit 0 of elig is never looked at.
  function automatic logic [2:0] rr_pick(input logic [3:0] elig, input logic [1:0] ptr);
    logic [1:0] order [3];
    logic [2:0] pick;
    case (ptr)
      RQ_68K:  order = '{RQ_68K, RQ_Z80, RQ_SPRITES};
      RQ_Z80:  order = '{RQ_Z80, RQ_SPRITES, RQ_68K};
      default: order = '{RQ_SPRITES, RQ_68K, RQ_Z80};
    endcase
    pick = 3'b000;
    // Walk from lowest to highest priority so the first in order wins last.
    for (int k = 2; k >= 0; k--) begin
      if (elig[order[k]]) pick = {1'b1, order[k]};
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rom_hit_buf.sv
`default_nettype none
// ============================================================================
// rom_hit_buf
// ----------------------------------------------------------------------------
// One-entry read buffer for a single requester (valid, address tag, data).
// Ports:
//   clk_main  in   clock
//   reset     in   asynchronous active-high reset, empties the entry
//   flush     in   invalidate the entry (wins over a same-cycle fill)
//   fill      in   capture cur_addr/fill_data and mark the entry valid
//   cur_addr  in   address being looked up / filled
//   fill_data in   data word to store
//   hit       out  entry valid and tag equals cur_addr
//   data      out  stored data word
// Revision: 1.0 - initial release
// ============================================================================
module rom_hit_buf
  import rom_arbiter_pkg::*;
(
  input  logic              clk_main,
  input  logic              reset,
  input  logic              flush,
  input  logic              fill,
  input  logic [ADDR_W-1:0] cur_addr,
  input  logic [DATA_W-1:0] fill_data,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic              valid;
  logic [ADDR_W-1:0] tag;

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else begin
      if (fill) begin
        tag  <= cur_addr;
        data <= fill_data;
      end
      if (flush)     valid <= 1'b0;
      else if (fill) valid <= 1'b1;
    end
  end

  assign hit = valid && (tag == cur_addr);

endmodule
`default_nettype wire

// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
// rom_arbiter
// ----------------------------------------------------------------------------
// Four-port ROM read arbiter with a one-entry hit buffer per requester.
// Requester 0 has fixed priority; 1..3 share a round-robin pointer.
// Ports:
//   clk_main    in   master clock, rising edge
//   reset       in   asynchronous active-high reset
//   req[3:0]    in   request levels
//   addr[95:0]  in   four 24-bit word addresses, requester i at [24i+23:24i]
//   ack[3:0]    out  one-cycle completion pulse, rdata valid alongside
//   rdata[15:0] out  returned word, held between acks
//   flush       in   invalidate all hit buffers
//   mem_req     out  memory read strobe, held until mem_ack or timeout
//   mem_addr    out  memory word address
//   mem_rdata   in   memory read data
//   mem_ack     in   memory completion pulse
//   timeout_err out  sticky memory-timeout flag
// Timing: grant cycle G, hit ack in G+2; on a miss mem_req rises in G+2 and
// ack follows the cycle after mem_ack.
// Revision: 1.0 - initial release
// ============================================================================
module rom_arbiter
  import rom_arbiter_pkg::*;
(
  input  logic                     clk_main,
  input  logic                     reset,
  input  logic [NUM_RQ-1:0]        req,
  input  logic [NUM_RQ*ADDR_W-1:0] addr,
  output logic [NUM_RQ-1:0]        ack,
  output logic [DATA_W-1:0]        rdata,
  input  logic                     flush,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ack,
  output logic                     timeout_err
);

  state_e            state;
  logic [1:0]        gnt_idx;
  logic [ADDR_W-1:0] gnt_addr;
  logic [1:0]        rr_ptr;
  logic [7:0]        wait_cnt;

  logic [ADDR_W-1:0] addr_arr [NUM_RQ];
  logic [NUM_RQ-1:0] eligible;
  logic              grant_valid;
  logic [1:0]        grant_sel;
  logic [2:0]        rr_result;

  logic [NUM_RQ-1:0] buf_hit;
  logic [NUM_RQ-1:0] buf_fill;
  logic [DATA_W-1:0] buf_data [NUM_RQ];
  logic              fill_now;
  logic              sel_hit;
  logic [DATA_W-1:0] sel_data;

  // A requester is not eligible in its own ack cycle, so a level request
  // that has just been served is not re-granted before it can drop.
  assign eligible  = req & ~ack;
  assign rr_result = rr_pick(eligible, rr_ptr);

  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = RQ_PLANES;
    if (eligible[RQ_PLANES]) begin
      grant_valid = 1'b1;
    end else if (rr_result[2]) begin
      grant_valid = 1'b1;
      grant_sel   = rr_result[1:0];
    end
  end

  // Buffer fill only on a real memory completion, never on a timeout.
  assign fill_now = (state == ST_WAIT) && mem_ack;

  genvar g;
  generate
    for (g = 0; g < NUM_RQ; g++) begin : g_buf
      assign addr_arr[g] = addr[g*ADDR_W +: ADDR_W];
      assign buf_fill[g] = fill_now && (gnt_idx == 2'(g));

      rom_hit_buf u_hit_buf (
        .clk_main  (clk_main),
        .reset     (reset),
        .flush     (flush),
        .fill      (buf_fill[g]),
        .cur_addr  (gnt_addr),
        .fill_data (mem_rdata),
        .hit       (buf_hit[g]),
        .data      (buf_data[g])
      );
    end
  endgenerate

  assign sel_hit  = buf_hit[gnt_idx];
  assign sel_data = buf_data[gnt_idx];

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      gnt_idx     <= RQ_PLANES;
      gnt_addr    <= '0;
      rr_ptr      <= RQ_SPRITES;
      wait_cnt    <= '0;
      ack         <= '0;
      rdata       <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      timeout_err <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            gnt_idx  <= grant_sel;
            gnt_addr <= addr_arr[grant_sel];
            if (grant_sel != RQ_PLANES) begin
              rr_ptr <= (grant_sel == RQ_Z80) ? RQ_SPRITES : grant_sel + 2'd1;
            end
            state <= ST_ISSUE;
          end
        end

        // Hit check against the latched address; miss starts the access.
        ST_ISSUE: begin
          if (sel_hit) begin
            ack   <= 4'b0001 << gnt_idx;
            rdata <= sel_data;
            state <= ST_IDLE;
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= gnt_addr;
            wait_cnt <= '0;
            state    <= ST_WAIT;
          end
        end

        // wait_cnt holds the number of WAIT cycles already elapsed; the
        // access is abandoned when the current cycle would be the 255th.
        ST_WAIT: begin
          if (mem_ack) begin
            ack      <= 4'b0001 << gnt_idx;
            rdata    <= mem_rdata;
            mem_req  <= 1'b0;
            wait_cnt <= '0;
            state    <= ST_IDLE;
          end else if (wait_cnt == TIMEOUT - 8'd1) begin
            ack         <= 4'b0001 << gnt_idx;
            rdata       <= TIMEOUT_DATA;
            timeout_err <= 1'b1;
            mem_req     <= 1'b0;
            wait_cnt    <= '0;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
